// File: rtl/tub_reg_translator_pkg.sv
// Shared constants for the trigger utility board register translator.
// Mode encodings and parameter limits used by the top and the per-channel stretcher.
package tub_pkg;
   localparam logic MODE_REG        = 1'b0;
   localparam logic MODE_STRETCH    = 1'b1;
   localparam int   SYNC_STAGES_MAX = 4;
   localparam int   CNT_W_DEF       = 8;
endpackage

// File: rtl/tub_stretch_chan.sv
// One trigger channel: edge detect against the previous synchronised level,
// then either registered pass-through or a retriggerable pulse stretcher.
module tub_stretch_chan
   import tub_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclr,
   input  logic             ds,
   input  logic             en,
   input  logic             mode,
   input  logic [CNT_W-1:0] stretch_len,
   output logic             q,
   output logic             edge_pulse
);

   logic             prev;
   logic             rise;
   logic             q_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   assign rise = ds & ~prev & en;

   // A rise always reloads, so a retrigger extends the pulse and beats cnt hitting 0.
   always_comb begin
      q_nxt   = 1'b0;
      cnt_nxt = '0;
      if (mode == MODE_REG) begin
         q_nxt = ds & en;
      end else if (!en) begin
         q_nxt = 1'b0;
      end else if (rise) begin
         q_nxt   = 1'b1;
         cnt_nxt = (stretch_len == '0) ? '0 : stretch_len - CNT_W'(1);
      end else if (cnt != '0) begin
         q_nxt   = 1'b1;
         cnt_nxt = cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev       <= 1'b0;
         cnt        <= '0;
         q          <= 1'b0;
         edge_pulse <= 1'b0;
      end else if (sclr) begin
         prev       <= 1'b0;
         cnt        <= '0;
         q          <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         prev       <= ds;
         cnt        <= cnt_nxt;
         q          <= q_nxt;
         edge_pulse <= rise;
      end
   end

endmodule

// File: rtl/tub_reg_translator.sv
// Registered ECL-to-TTL trigger translator: optional synchroniser chain feeding
// WIDTH per-channel mask / edge-detect / pulse-stretch lanes.
module tub_reg_translator
   import tub_pkg::*;
#(
   parameter int WIDTH       = 6,
   parameter int SYNC_STAGES = 0,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             MR_,
   input  logic             SCLR,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] EN,
   input  logic             MODE,
   input  logic [CNT_W-1:0] STRETCH_LEN,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] EDGE
);

   // Out-of-range depths are clamped rather than left to build an oversized chain.
   localparam int STAGES = (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                           (SYNC_STAGES < 0)               ? 0 : SYNC_STAGES;

   logic [WIDTH-1:0] ds;

   if (STAGES == 0) begin : g_nosync
      assign ds = D;
   end else begin : g_sync
      logic [STAGES-1:0][WIDTH-1:0] sync_q;

      always_ff @(posedge CLK or negedge MR_) begin
         if (!MR_) begin
            sync_q <= '0;
         end else if (SCLR) begin
            sync_q <= '0;
         end else begin
            sync_q[0] <= D;
            for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
         end
      end

      assign ds = sync_q[STAGES-1];
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      tub_stretch_chan #(.CNT_W(CNT_W)) u_chan (
         .clk         (CLK),
         .rst_n       (MR_),
         .sclr        (SCLR),
         .ds          (ds[i]),
         .en          (EN[i]),
         .mode        (MODE),
         .stretch_len (STRETCH_LEN),
         .q           (Q[i]),
         .edge_pulse  (EDGE[i])
      );
   end

endmodule
